serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. It processes WIDTH-bit operands one bit per clock through a single full-adder cell and a carry flip-flop.
- It is the sequential successor to the team's combinational full adder/subtractor cells.
- It targets area-constrained datapaths where multi-cycle latency is acceptable.
- A start/busy/done handshake frames each operation. Results are held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  single-cycle pulse: result valid.
- sum  output  WIDTH  result (two's-complement wrap), held after done.
- cout  output  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand shift registers, carry flop and counter are cleared.
  - Reset during RUN or DONE aborts the operation; no done pulse is issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch a into shift register A.
  - Latch (mode ? ~b : b) into shift register B.
  - Set carry = mode and counter = 0, then go to RUN.
  - With start=0: stay in IDLE; outputs hold their previous values.
- RUN, each cycle:
  - s = A[0] ^ B[0] ^ carry.
  - carry <= majority(A[0], B[0], carry).
  - Shift A and B right by 1.
  - Shift s into the result register from the MSB side.
  - On the cycle that processes bit WIDTH-1, also capture carry-in to the MSB for ovf.
  - Counter increments. After WIDTH bits, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - sum, cout and ovf are valid and updated on entry to DONE.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge k gives busy=1 after edges k+1 .. k+WIDTH, and done=1 after edge k+WIDTH+1. That is WIDTH+1 cycles from start to done.
- Start handling:
  - start is ignored in RUN and DONE; no queueing.
  - Back-to-back operations require start asserted in the IDLE cycle following done.
  - mode, a and b are don't-care except in the IDLE cycle where start=1.
- Result register rules:
  - sum/cout/ovf change only on entry to DONE (or on reset).
  - Partial results are never visible on sum during RUN.
- Arithmetic:
  - Modulo 2^WIDTH.
  - cout and ovf follow standard two's-complement adder definitions applied to a + (b XOR mode) + mode.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=8, add 0x35+0x4A:
  - Expect sum=0x7F, cout=0, ovf=0.
  - done exactly 9 cycles after the start edge; busy high for 8 cycles.
- Add 0x7F+0x01, expect sum=0x80, cout=0, ovf=1.
- Add 0xFF+0x01, expect sum=0x00, cout=1, ovf=0.
- Subtract 0x10-0x20, expect sum=0xF0, cout=0 (borrow), ovf=0.
- Subtract 0x80-0x01, expect sum=0x7F, cout=1, ovf=1.
- Start ignored while busy:
  - Pulse start with different operands at RUN cycle 3.
  - Expect the original result and a single done pulse.
- Reset mid-operation:
  - Assert rst at RUN cycle 4.
  - Expect sum/cout/ovf/busy/done=0 and no done pulse.
  - A subsequent add 0x01+0x02 yields 0x03.
- Exhaustive sweep at WIDTH=4:
  - Run all a, b and mode combinations back-to-back (start in the IDLE cycle after each done).
  - Compare each result against a reference model.

Source files
------------

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_if
// Description : Start/busy/done handshake and operand/result bus for the
//               bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial adder/subtractor, one full-adder cell and a carry
//               flop, LSB first, WIDTH+1 cycles from start to done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_addsub_if.slave bus
);
    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_RUN  = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;
    logic             w_busy;
    logic             w_done;

    assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last  = (r_cnt == c_LAST);
    assign w_shift = {w_s, r_res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_next_state = c_RUN;
            c_RUN:   if (w_last)    w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_RUN:   w_busy = 1'b1;
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Subtract is a + ~b + 1: invert B at load and seed the carry with mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.mode ? ~bus.b : bus.b;
                        r_carry <= bus.mode;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_res   <= w_shift[WIDTH-1:1];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // On the MSB cycle r_carry is the carry into the MSB.
                    if (w_last) begin
                        r_sum  <= w_shift;
                        r_cout <= w_c;
                        r_ovf  <= r_carry ^ w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Directed checks at WIDTH=8 plus a full sweep at WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [7:0] last_sum;

    serial_addsub_if #(.WIDTH(8)) if8 ();
    serial_addsub_if #(.WIDTH(4)) if4 ();

    serial_addsub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_addsub #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-cycle check of one 8-bit operation; poke>0 re-asserts start with
    // other operands in that RUN cycle, which must be ignored.
    task automatic op8(input string tag, input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec, input logic eo, input int poke);
        if8.start = 1'b1;
        if8.mode  = m;
        if8.a     = a;
        if8.b     = b;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if8.start = (i == poke);
            if (i == poke) begin
                if8.mode = 1'b1;
                if8.a    = 8'hFF;
                if8.b    = 8'hFF;
            end
            chk($sformatf("%s busy c%0d", tag, i), if8.busy, (i <= 8));
            chk($sformatf("%s done c%0d", tag, i), if8.done, (i == 9));
            if (i <= 8) chk($sformatf("%s sum_hold c%0d", tag, i), if8.sum, last_sum);
        end
        chk({tag, " sum"},  if8.sum,  es);
        chk({tag, " cout"}, if8.cout, ec);
        chk({tag, " ovf"},  if8.ovf,  eo);
        last_sum = es;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("%s post done %0d", tag, i), if8.done, 1'b0);
            chk($sformatf("%s post busy %0d", tag, i), if8.busy, 1'b0);
        end
    endtask

    task automatic op4(input logic m, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] full;
        logic [3:0] low;
        logic [3:0] bx;
        bit         seen;
        bx   = b ^ {4{m}};
        full = {1'b0, a} + {1'b0, bx} + {4'b0, m};
        low  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b0, m};
        if4.start = 1'b1;
        if4.mode  = m;
        if4.a     = a;
        if4.b     = b;
        tick();
        if4.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if4.done) seen = 1'b1;
            else tick();
        end
        chk($sformatf("w4 done m%0d a%0h b%0h", m, a, b), seen, 1'b1);
        chk($sformatf("w4 sum m%0d a%0h b%0h", m, a, b),  if4.sum,  full[3:0]);
        chk($sformatf("w4 cout m%0d a%0h b%0h", m, a, b), if4.cout, full[4]);
        chk($sformatf("w4 ovf m%0d a%0h b%0h", m, a, b),  if4.ovf,  full[4] ^ low[3]);
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        last_sum = 8'h00;
        rst = 1'b1;
        if8.start = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.mode = 1'b0; if4.a = '0; if4.b = '0;
        tick();
        tick();
        chk("reset busy", if8.busy, 1'b0);
        chk("reset done", if8.done, 1'b0);
        chk("reset sum",  if8.sum,  8'h00);
        chk("reset cout", if8.cout, 1'b0);
        chk("reset ovf",  if8.ovf,  1'b0);
        chk("reset w4 sum", if4.sum, 4'h0);
        rst = 1'b0;
        tick();

        op8("add 35+4A", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 0);
        op8("add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        op8("add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        op8("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 0);
        op8("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);
        op8("start in run", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 3);

        // Abort an add of 7F+01 with reset in RUN cycle 4.
        if8.start = 1'b1; if8.mode = 1'b0; if8.a = 8'h7F; if8.b = 8'h01;
        tick();
        if8.start = 1'b0;
        for (int i = 2; i <= 4; i++) tick();
        chk("pre abort busy", if8.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", if8.busy, 1'b0);
        chk("abort done", if8.done, 1'b0);
        chk("abort sum",  if8.sum,  8'h00);
        chk("abort cout", if8.cout, 1'b0);
        chk("abort ovf",  if8.ovf,  1'b0);
        last_sum = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("abort no done %0d", i), if8.done, 1'b0);
        end
        op8("add 01+02", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0);

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op4(m[0], a[3:0], b[3:0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
